// File: rtl/dff_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter in front of the
// shared 2:1-mux storage flop.
package dff_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_LOCK_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [$clog2(N_REQ_DEF)-1:0] idx_t;

  function automatic logic [N_REQ_DEF-1:0] onehot(input idx_t i);
    logic [N_REQ_DEF-1:0] v;
    v    = {N_REQ_DEF{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dff_mux_arbiter_rr_pick.sv
// Rotate-priority finder: first set request at or after the pointer,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // Scan from the pointer upward and keep only the first hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    for (int k = 0; k < N; k++) begin
      idx_o   = (req_i[(int'(ptr_i) + k) % N] && !found_o) ? W'((int'(ptr_i) + k) % N) : idx_o;
      found_o = found_o | req_i[(int'(ptr_i) + k) % N];
    end
  end

endmodule

// File: rtl/dff_mux_arbiter.sv
// Round-robin arbiter sharing one registered 2:1-mux flop between N_REQ
// requesters, with bounded burst locking for the current owner.
module dff_mux_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [2*N_REQ-1:0]       d_in,
  input  logic [N_REQ-1:0]         sel_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     Q
);

  localparam int W  = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]    LOCK_LIM = CW'(MAX_LOCK - 1);
  localparam logic [W-1:0]     LAST     = W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [W-1:0]      ptr_q;
  logic [W-1:0]      owner_q;
  logic [CW-1:0]     lock_cnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  ack_q;
  logic              busy_q;
  logic              q_q;

  logic              keep_d;
  logic [W-1:0]      ptr_d;
  logic              found_d;
  logic [W-1:0]      pick_d;
  logic              cap_d;

  assign cap_d  = sel_in[owner_q] ? d_in[{owner_q, 1'b1}] : d_in[{owner_q, 1'b0}];
  assign keep_d = (state_q == GRANT) && lock[owner_q] && req[owner_q] && (lock_cnt_q < LOCK_LIM);
  // A releasing owner moves the pointer past itself before the same-edge re-arbitration.
  assign ptr_d  = (state_q == GRANT) ? ((owner_q == LAST) ? {W{1'b0}} : owner_q + W'(1)) : ptr_q;

  rr_pick #(.N(N_REQ), .W(W)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_d),
    .found_o (found_d),
    .idx_o   (pick_d)
  );

  // Arbitration FSM, shared capture flop and registered grant/ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= {W{1'b0}};
      owner_q    <= {W{1'b0}};
      lock_cnt_q <= {CW{1'b0}};
      gnt_q      <= {N_REQ{1'b0}};
      ack_q      <= {N_REQ{1'b0}};
      busy_q     <= 1'b0;
      q_q        <= 1'b0;
    end else begin
      if (state_q == GRANT) begin
        q_q   <= cap_d;
        ack_q <= ONE << owner_q;
      end else begin
        ack_q <= {N_REQ{1'b0}};
      end
      if (keep_d) begin
        lock_cnt_q <= lock_cnt_q + CW'(1);
      end else begin
        lock_cnt_q <= {CW{1'b0}};
        ptr_q      <= ptr_d;
        if (found_d) begin
          state_q <= GRANT;
          owner_q <= pick_d;
          gnt_q   <= ONE << pick_d;
          busy_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          gnt_q   <= {N_REQ{1'b0}};
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign Q     = q_q;

endmodule

// File: tb/tb_dff_mux_arbiter.sv
// Directed bench for dff_mux_arbiter with hand-computed expectations.
module tb_dff_mux_arbiter;
  import dff_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [7:0] d_in;
  logic [3:0] sel_in;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic [1:0] owner;
  logic       busy;
  logic       Q;

  int tests = 0;
  int fails = 0;

  // Muxed bit of each requester during the round-robin and lock phases.
  logic [3:0] qexp;
  logic [1:0] lk_own [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};

  always #5 clk = ~clk;

  dff_mux_arbiter #(.N_REQ(4), .MAX_LOCK(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lock   (lock),
    .d_in   (d_in),
    .sel_in (sel_in),
    .gnt    (gnt),
    .ack    (ack),
    .owner  (owner),
    .busy   (busy),
    .Q      (Q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic [1:0] pair, input logic s);
    d_in[2*i +: 2] = pair;
    sel_in[i]      = s;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; lock = 4'b0000; d_in = 8'h00; sel_in = 4'b0000;
    step(); step();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_ack", ack, 4'b0000);
    check("rst_q", Q, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 2'd0);

    // first grant after release goes to requester 0
    rst = 1'b0; set_rq(0, 2'b01, 1'b0);
    step();
    check("first_gnt", gnt, onehot(2'd0));
    check("first_busy", busy, 1'b1);
    req = 4'b0000;
    step();
    check("first_q", Q, 1'b1);
    check("first_ack", ack, 4'b0001);
    check("first_idle_gnt", gnt, 4'b0000);
    check("first_idle_busy", busy, 1'b0);
    check("owner_hold", owner, 2'd0);

    // single writer, requester 2
    req = 4'b0100; set_rq(2, 2'b10, 1'b1);
    step();
    check("sw_gnt", gnt, 4'b0100);
    check("sw_owner", owner, 2'd2);
    check("sw_no_ack", ack, 4'b0000);
    step();
    check("sw_q_sel1", Q, 1'b1);
    check("sw_ack", ack, 4'b0100);
    check("sw_regnt", gnt, 4'b0100);
    sel_in[2] = 1'b0;
    step();
    check("sw_q_sel0", Q, 1'b0);
    check("sw_ack2", ack, 4'b0100);
    req = 4'b0000;
    step(); step();
    check("sw_end_gnt", gnt, 4'b0000);
    check("sw_end_ack", ack, 4'b0000);

    // sole requester 3 with pointer at 3
    req = 4'b1000; set_rq(3, 2'b01, 1'b0);
    step();
    check("wr_gnt", gnt, 4'b1000);
    check("wr_owner", owner, 2'd3);
    step();
    check("wr_q1", Q, 1'b1);
    check("wr_ack1", ack, 4'b1000);
    check("wr_regnt1", gnt, 4'b1000);
    sel_in[3] = 1'b1;
    step();
    check("wr_q2", Q, 1'b0);
    check("wr_ack2", ack, 4'b1000);
    check("wr_regnt2", gnt, 4'b1000);
    req = 4'b0000;
    step(); step();

    // round robin with all requesters
    set_rq(0, 2'b01, 1'b0); set_rq(1, 2'b10, 1'b0);
    set_rq(2, 2'b10, 1'b1); set_rq(3, 2'b00, 1'b1);
    qexp = 4'b0101;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_owner", owner, 32'(k % 4));
      check("rr_gnt", gnt, onehot(idx_t'(k % 4)));
      if (k > 0) begin
        check("rr_q", Q, qexp[(k - 1) % 4]);
        check("rr_ack", ack, onehot(idx_t'((k - 1) % 4)));
      end
    end
    req = 4'b0000;
    step(); step();

    // requester 0 locks against requester 1
    req = 4'b0011; lock = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step();
      check("lk_owner", owner, lk_own[k]);
      if (k > 0) begin
        check("lk_q", Q, qexp[lk_own[k - 1]]);
      end
    end
    lock = 4'b0000;
    step();
    check("nolk_owner0", owner, 2'd0);
    step();
    check("nolk_owner1", owner, 2'd1);

    // reset in the middle of a locked burst of requester 1
    set_rq(1, 2'b11, 1'b0); lock = 4'b0010; req = 4'b0010;
    step();
    check("mb_q", Q, 1'b1);
    check("mb_gnt", gnt, 4'b0010);
    rst = 1'b1;
    step();
    check("mb_rst_gnt", gnt, 4'b0000);
    check("mb_rst_q", Q, 1'b0);
    check("mb_rst_ack", ack, 4'b0000);
    check("mb_rst_busy", busy, 1'b0);
    check("mb_rst_owner", owner, 2'd0);
    rst = 1'b0; req = 4'b1111; lock = 4'b0000;
    step();
    check("mb_ptr0_gnt", gnt, 4'b0001);
    check("mb_post_ack", ack, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff_mux_arbiter.md
Name: dff_mux_arbiter

Overview:
- Shares one registered 2:1-mux D flip-flop (sel picks D[1] or D[0]; synchronous active-high reset clears Q) between N_REQ requesters.
- Each requester presents a 2-bit D pair and a select.
- The arbiter grants one requester per cycle using a round-robin pointer and captures that requester's muxed bit into the shared register.
- Optional lock lets a requester keep the register for a bounded burst; it sits between testcase/sequencer logic and the storage flop.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_LOCK, 3, max consecutive locked captures by one owner before the lock is ignored for one arbitration

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous reset, active-high
- req  input  N_REQ  per-requester write request
- lock  input  N_REQ  per-requester burst-hold request, qualified by req
- d_in  input  2*N_REQ  requester i data pair at bits [2i+1:2i]
- sel_in  input  N_REQ  requester i select: 1 -> d_in[2i+1], 0 -> d_in[2i]
- gnt  output  N_REQ  registered one-hot grant
- ack  output  N_REQ  registered one-hot pulse, one cycle, after capture
- owner  output  $clog2(N_REQ)  index of current grantee (valid when busy)
- busy  output  1  some gnt bit high
- Q  output  1  shared register value

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: gnt=0, ack=0, owner=0, busy=0, Q=0, rr pointer=0, lock count=0, FSM=IDLE.
- Reset mid-burst wins over everything: all of the above are restored at that edge and no capture occurs.
- FSM states: IDLE (no grant) and GRANT (gnt one-hot for owner).
- Arbitration at every edge where rst=0:
  - The winner is the first i with req[i]=1 searching pointer, pointer+1, ... mod N_REQ.
  - No req -> go to IDLE, gnt=0.
- Capture: at any edge while in GRANT, Q <= sel_in[owner] ? d_in[2*owner+1] : d_in[2*owner].
  - ack[owner] is high for the following cycle.
  - The capture is unconditional; a requester must hold req, d_in and sel_in stable from assertion until it sees its gnt bit high at a clock edge.
- Next owner decided at the capture edge:
  - If lock[owner] and req[owner] and lock count < MAX_LOCK-1: keep the same owner and increment lock count.
  - Otherwise set pointer = owner+1 (mod N_REQ), clear lock count, and re-arbitrate the same edge with the new pointer.
  - The previous owner may win again only if no other req is high.
- Latency: req high sampled in IDLE at edge E0 -> gnt high after E0 -> capture at E1 -> Q and ack visible after E1.
- Throughput: back-to-back grants give one capture per cycle with no bubble.
- Simultaneous requests: pointer order only; lock never preempts a current owner.
- Dropped request: a requester that drops req while granted is still captured once at that edge. Illegal per protocol; the bench flags it.
- Lock limit: MAX_LOCK=1 disables locking. A locked owner gets exactly MAX_LOCK consecutive captures, then must re-arbitrate.
- Pointer wraps from N_REQ-1 to 0.
- Invariants: gnt and ack are always one-hot or zero; busy = |gnt; owner holds its last value while IDLE.

Decomposition:
- Package dff_arb_pkg:
  - state enum {IDLE, GRANT}
  - default N_REQ and MAX_LOCK constants
  - idx_t = logic [$clog2(N_REQ)-1:0]
  - helper function onehot(idx_t)
- Sub-module rr_pick: combinational rotate-priority finder (req, pointer -> found, index), instantiated once.
- The shared mux-register is implemented inline in this block, with the same semantics as the existing flop.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all req=1 -> gnt=0, ack=0, Q=0, busy=0. Release -> requester 0 is granted first.
- Single writes: only req[2]=1, d_in pair=2'b10, sel=1 -> gnt[2] after 1 edge, Q=1 and ack[2] after 2 edges. Repeat with sel=0 -> Q=0.
- Round robin: req=4'b1111 held for 8 cycles -> owner sequence 0,1,2,3,0,1,2,3 with no bubbles; Q tracks each requester's muxed bit.
- Lock limit: req=4'b0011, lock[0]=1, MAX_LOCK=3 -> owner sequence 0,0,0,1,0,0,0,1. lock[0]=0 -> alternates 0,1.
- Wrap and sole requester: pointer at 3, only req[3]=1 -> requester 3 is re-granted each cycle, one capture per cycle.
- Mid-burst reset: rst=1 during a locked burst of requester 1 -> next cycle gnt=0, Q=0, pointer=0, and no ack pulse.
